my_top_level: RTL and testbench

MY_TOP_LEVEL -- requirements
Module: my_top_level

---
 rtl/my_top_level.sv | 61 ++++++
 tb/tb_my_top_level.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/my_top_level.sv
// Registered unsigned adder with optional clamp-on-overflow and a
// configurable-depth output delay pipeline.
module my_top_level #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LATENCY  = 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_A,
    input  logic [WIDTH-1:0] io_B,
    output logic [WIDTH-1:0] io_X
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "my_top_level: WIDTH must be in 1..32");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $fatal(1, "my_top_level: LATENCY must be in 1..4");
    end
    if (SATURATE > 1) begin : g_bad_saturate
        $fatal(1, "my_top_level: SATURATE must be 0 or 1");
    end

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] pipe_d [LATENCY];
    logic [WIDTH-1:0] pipe_q [LATENCY];

    always_comb begin
        sum = {1'b0, io_A} + {1'b0, io_B};
        if ((SATURATE != 0) && sum[WIDTH]) begin
            result = '1;
        end else begin
            result = sum[WIDTH-1:0];
        end
    end

    // Stage 0 captures the finished sum; later stages only delay it.
    always_comb begin
        pipe_d[0] = result;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign io_X = pipe_q[LATENCY-1];

endmodule

// File: tb/tb_my_top_level.sv
// Directed bench for my_top_level: three instances share operands and reset
// (wrap/LATENCY=1, clamp/LATENCY=1, wrap/LATENCY=3).
module tb_my_top_level;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [7:0] x_l1;
    logic [7:0] x_sat;
    logic [7:0] x_l3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    my_top_level #(.WIDTH(8), .LATENCY(1), .SATURATE(0)) u_dut_l1 (
        .clk(clk), .reset(reset), .io_A(a), .io_B(b), .io_X(x_l1)
    );
    my_top_level #(.WIDTH(8), .LATENCY(1), .SATURATE(1)) u_dut_sat (
        .clk(clk), .reset(reset), .io_A(a), .io_B(b), .io_X(x_sat)
    );
    my_top_level #(.WIDTH(8), .LATENCY(3), .SATURATE(0)) u_dut_l3 (
        .clk(clk), .reset(reset), .io_A(a), .io_B(b), .io_X(x_l3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        a = 8'h12;
        b = 8'h34;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks += 3;
            if (x_l1 !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold_l1 cycle %0d: got %h want 00", i, x_l1);
            end
            if (x_sat !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold_sat cycle %0d: got %h want 00", i, x_sat);
            end
            if (x_l3 !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold_l3 cycle %0d: got %h want 00", i, x_l3);
            end
        end
        reset = 1'b1;
        tick();
        checks += 3;
        if (x_l1 !== 8'h46) begin
            errors++;
            $display("FAIL reset_release_l1: got %h want 46", x_l1);
        end
        if (x_sat !== 8'h46) begin
            errors++;
            $display("FAIL reset_release_sat: got %h want 46", x_sat);
        end
        if (x_l3 !== 8'h00) begin
            errors++;
            $display("FAIL reset_release_l3: got %h want 00", x_l3);
        end
    endtask

    task automatic test_stream;
        logic [3199:0] word;
        logic [7:0]    exp_mod [200];
        logic [7:0]    pa;
        logic [7:0]    pb;
        int            s;
        logic [7:0]    exp_sat;
        for (int k = 0; k < 400; k++) begin
            word[8*k +: 8] = 8'((k * 37 + 11) % 256);
        end
        for (int k = 0; k < 200; k++) begin
            pa = word[16*k +: 8];
            pb = word[16*k + 8 +: 8];
            a = pa;
            b = pb;
            s = int'(pa) + int'(pb);
            exp_mod[k] = 8'(s % 256);
            exp_sat = (s > 255) ? 8'hFF : 8'(s);
            tick();
            checks += 2;
            if (x_l1 !== exp_mod[k]) begin
                errors++;
                $display("FAIL stream_l1 pair %0d: got %h want %h", k, x_l1, exp_mod[k]);
            end
            if (x_sat !== exp_sat) begin
                errors++;
                $display("FAIL stream_sat pair %0d: got %h want %h", k, x_sat, exp_sat);
            end
            if (k >= 2) begin
                checks++;
                if (x_l3 !== exp_mod[k-2]) begin
                    errors++;
                    $display("FAIL stream_l3 pair %0d: got %h want %h", k - 2, x_l3, exp_mod[k-2]);
                end
            end
        end
    endtask

    task automatic test_overflow;
        logic [7:0] va   [4] = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0] vb   [4] = '{8'h00, 8'h00, 8'h01, 8'hFF};
        logic [7:0] wrap [4] = '{8'h00, 8'hFF, 8'h00, 8'hFE};
        logic [7:0] sat  [4] = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            a = va[i];
            b = vb[i];
            tick();
            checks += 2;
            if (x_l1 !== wrap[i]) begin
                errors++;
                $display("FAIL overflow_wrap %h+%h: got %h want %h", va[i], vb[i], x_l1, wrap[i]);
            end
            if (x_sat !== sat[i]) begin
                errors++;
                $display("FAIL overflow_sat %h+%h: got %h want %h", va[i], vb[i], x_sat, sat[i]);
            end
        end
    endtask

    task automatic test_latency3;
        logic [7:0] want [4] = '{8'h00, 8'h00, 8'h0F, 8'h00};
        a = 8'h00;
        b = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        a = 8'h05;
        b = 8'h0A;
        for (int i = 0; i < 4; i++) begin
            tick();
            a = 8'h00;
            b = 8'h00;
            checks++;
            if (x_l3 !== want[i]) begin
                errors++;
                $display("FAIL latency3 edge N+%0d: got %h want %h", i, x_l3, want[i]);
            end
        end
    endtask

    task automatic test_midstream_reset;
        logic [7:0] want;
        for (int i = 1; i <= 5; i++) begin
            a = 8'(i);
            b = 8'(i + 16);
            tick();
            checks++;
            if (x_l1 !== 8'(2 * i + 16)) begin
                errors++;
                $display("FAIL midrst_pre_l1 %0d: got %h want %h", i, x_l1, 8'(2 * i + 16));
            end
        end
        reset = 1'b0;
        a = 8'h77;
        b = 8'h11;
        tick();
        checks += 3;
        if (x_l1 !== 8'h00) begin
            errors++;
            $display("FAIL midrst_edge_l1: got %h want 00", x_l1);
        end
        if (x_sat !== 8'h00) begin
            errors++;
            $display("FAIL midrst_edge_sat: got %h want 00", x_sat);
        end
        if (x_l3 !== 8'h00) begin
            errors++;
            $display("FAIL midrst_edge_l3: got %h want 00", x_l3);
        end
        reset = 1'b1;
        for (int j = 0; j < 5; j++) begin
            a = 8'(32 + j);
            b = 8'(48 + j);
            tick();
            want = 8'(80 + 2 * j);
            checks += 3;
            if (x_l1 !== want) begin
                errors++;
                $display("FAIL midrst_post_l1 %0d: got %h want %h", j, x_l1, want);
            end
            if (x_sat !== want) begin
                errors++;
                $display("FAIL midrst_post_sat %0d: got %h want %h", j, x_sat, want);
            end
            want = (j < 2) ? 8'h00 : 8'(80 + 2 * (j - 2));
            if (x_l3 !== want) begin
                errors++;
                $display("FAIL midrst_post_l3 %0d: got %h want %h", j, x_l3, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_latency3();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
